// File: rtl/equiv_pkg.sv
// Shared definitions for the exhaustive equivalence checker.
// Holds the sweep FSM encoding, the default settle time and the settle counter width.
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned SETTLE_DEFAULT = 2;
  // Four bits covers the legal settle range of 0..15.
  localparam int unsigned SETTLE_W       = 4;

endpackage

// File: rtl/settle_timer.sv
// Settle countdown for the equivalence checker.
// Ports: clk, rst_n   - clock and async active-low reset
//        load, value  - load the counter with value (load wins over counting)
//        en           - count down by one per cycle while nonzero
//        zero_c       - combinational flag, counter is zero
module settle_timer
  import equiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  input  logic                en,
  output logic                zero_c
);

  logic [SETTLE_W-1:0] cnt_q;

  // Countdown register: saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/equiv_checker.sv
// Exhaustive equivalence checker: sweeps every N_IN-bit vector, holds each one
// SETTLE+1 cycles, and compares the two expression results on the last cycle.
// Ports: clk, rst_n          - clock and async active-low reset
//        start               - one-cycle sweep request (ignored while busy)
//        lhs, rhs            - expression results from the block under check
//        vec_out             - applied vector, MSB drives X, LSB drives Z
//        busy, done          - sweep in progress / sweep complete
//        pass                - combinational: done with no mismatches
//        mismatch_cnt        - number of mismatching vectors
//        first_fail_vec      - lowest mismatching vector
//        first_fail_valid    - first_fail_vec holds a captured vector
module equiv_checker
  import equiv_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            lhs,
  input  logic            rhs,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int unsigned        CNT_W   = N_IN + 1;
  localparam logic [N_IN-1:0]    VEC_MAX = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_d;
  logic              busy_d, done_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [N_IN-1:0]   ffv_d;
  logic              ffvalid_d;
  logic              tmr_load;
  logic              tmr_zero_c;

  settle_timer u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (SETTLE_V),
    .en     (state_q == ST_HOLD),
    .zero_c (tmr_zero_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_out;
    busy_d    = busy;
    done_d    = done;
    cnt_d     = mismatch_cnt;
    ffv_d     = first_fail_vec;
    ffvalid_d = first_fail_valid;
    tmr_load  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_HOLD;
          vec_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          cnt_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      ST_HOLD: begin
        // Compare only on the last cycle of the hold window.
        if (tmr_zero_c) begin
          if (lhs != rhs) begin
            cnt_d = mismatch_cnt + CNT_W'(1);
            if (!first_fail_valid) begin
              ffv_d     = vec_out;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_out == VEC_MAX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d    = vec_out + N_IN'(1);
            tmr_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_out          <= vec_d;
      busy             <= busy_d;
      done             <= done_d;
      mismatch_cnt     <= cnt_d;
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffvalid_d;
    end
  end

  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_equiv_checker.sv
// Randomized self-checking bench for equiv_checker with default parameters.
module tb_equiv_checker;

  localparam int unsigned N     = 3;
  localparam int unsigned S     = 2;
  localparam int unsigned NV    = 1 << N;
  localparam int          SWEEP = NV * (S + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          lhs, rhs;
  logic [N-1:0]  vec_out;
  logic          busy, done, pass;
  logic [N:0]    mismatch_cnt;
  logic [N-1:0]  first_fail_vec;
  logic          first_fail_valid;

  // Emulated block under check: a random truth table, with fmask flipping rhs.
  logic [NV-1:0] tt;
  logic [NV-1:0] fmask;

  int tests_run;
  int tests_failed;

  equiv_checker #(.N_IN(N), .SETTLE(S)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .lhs              (lhs),
    .rhs              (rhs),
    .vec_out          (vec_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  assign lhs = tt[vec_out];
  assign rhs = tt[vec_out] ^ fmask[vec_out];

  // Reference model: expected result of a full sweep for a given mismatch set.
  function automatic int model_count(input logic [NV-1:0] m);
    int c = 0;
    for (int v = 0; v < NV; v++) if (m[v]) c++;
    return c;
  endfunction

  function automatic int model_first(input logic [NV-1:0] m);
    for (int v = 0; v < NV; v++) if (m[v]) return v;
    return 0;
  endfunction

  // Pulse start, optionally pulse it again restart_at edges later, and watch
  // the sweep. Reports the edge (relative to the start edge) where done rose
  // or -1 on timeout, and whether vec_out/busy/pass behaved throughout.
  task automatic run_sweep(input int restart_at, output int done_edge,
                           output bit seq_ok, output bit start_ok);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_ok  = (vec_out == '0) && busy && !done && !pass &&
                (mismatch_cnt == '0) && !first_fail_valid;
    seq_ok    = 1'b1;
    done_edge = -1;
    for (int m = 1; m <= SWEEP + 10; m++) begin
      if (m == restart_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        done_edge = m;
        break;
      end
      if (!busy || pass || (int'(vec_out) != m / (S + 1))) seq_ok = 1'b0;
    end
  endtask

  task automatic check_result(input string name, input int done_edge,
                              input bit seq_ok, input bit start_ok);
    int exp_cnt;
    int exp_first;
    exp_cnt   = model_count(fmask);
    exp_first = model_first(fmask);
    tests_run++;
    if (done_edge !== SWEEP) begin
      tests_failed++;
      $display("FAIL %s done_edge: got %0d, want %0d", name, done_edge, SWEEP);
    end
    tests_run++;
    if ({seq_ok, start_ok} !== 2'b11) begin
      tests_failed++;
      $display("FAIL %s sequence: seq_ok=%0b start_ok=%0b, want 1 1", name, seq_ok, start_ok);
    end
    tests_run++;
    if (int'(mismatch_cnt) !== exp_cnt) begin
      tests_failed++;
      $display("FAIL %s mismatch_cnt: got %0d, want %0d", name, mismatch_cnt, exp_cnt);
    end
    tests_run++;
    if (first_fail_valid !== (exp_cnt != 0) ||
        (exp_cnt != 0 && int'(first_fail_vec) !== exp_first)) begin
      tests_failed++;
      $display("FAIL %s first_fail: got valid=%0b vec=%0d, want valid=%0b vec=%0d",
               name, first_fail_valid, first_fail_vec, exp_cnt != 0, exp_first);
    end
    tests_run++;
    if ({pass, busy, vec_out} !== {exp_cnt == 0, 1'b0, N'(NV - 1)}) begin
      tests_failed++;
      $display("FAIL %s final: got pass=%0b busy=%0b vec=%0d, want pass=%0b busy=0 vec=%0d",
               name, pass, busy, vec_out, exp_cnt == 0, NV - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({vec_out, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: got vec=%0d busy=%0b done=%0b pass=%0b cnt=%0d ffv=%0d ffvalid=%0b, want all 0",
               vec_out, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, vec_out} !== '0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b vec=%0d, want 0 0 0", busy, done, vec_out);
    end
  endtask

  task automatic test_all_match();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = '0;
    run_sweep(0, de, so, st);
    check_result("all_match", de, so, st);
  endtask

  task automatic test_all_mismatch();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = '1;
    run_sweep(0, de, so, st);
    check_result("all_mismatch", de, so, st);
  endtask

  task automatic test_single_fail();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = NV'(1) << 5;
    run_sweep(0, de, so, st);
    check_result("single_fail_101", de, so, st);
  endtask

  task automatic test_random();
    int de; bit so, st;
    for (int i = 0; i < 6; i++) begin
      tt    = NV'($urandom);
      fmask = NV'($urandom);
      run_sweep(0, de, so, st);
      check_result($sformatf("random_%0d", i), de, so, st);
    end
  endtask

  task automatic test_start_ignored();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = NV'($urandom);
    run_sweep(10, de, so, st);
    check_result("start_in_hold", de, so, st);
  endtask

  task automatic test_reset_mid();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = '1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vec_out, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got vec=%0d busy=%0b done=%0b cnt=%0d ffv=%0d ffvalid=%0b, want all 0",
               vec_out, busy, done, mismatch_cnt, first_fail_vec, first_fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, vec_out, mismatch_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL idle_after_mid_reset: got busy=%0b done=%0b vec=%0d cnt=%0d, want 0",
               busy, done, vec_out, mismatch_cnt);
    end
    fmask = NV'($urandom);
    run_sweep(0, de, so, st);
    check_result("sweep_after_reset", de, so, st);
  endtask

  task automatic test_restart_from_done();
    int de; bit so, st;
    tt    = NV'($urandom);
    fmask = 8'b0110_0100;
    run_sweep(0, de, so, st);
    check_result("failing_before_restart", de, so, st);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({done, pass} !== 2'b10) begin
      tests_failed++;
      $display("FAIL done_held: got done=%0b pass=%0b, want 1 0", done, pass);
    end
    fmask = '0;
    run_sweep(0, de, so, st);
    check_result("restart_pass", de, so, st);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    tt           = '0;
    fmask        = '0;
    test_reset();
    test_all_match();
    test_all_mismatch();
    test_single_fail();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_restart_from_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/equiv_checker.md
EQUIV_CHECKER -- requirements
Module: equiv_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3, the number of DUT inputs swept (X,Y,Z).
REQ-002 SHALL have parameter SETTLE, default 2, the number of extra cycles each vector is held before lhs/rhs are compared; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  a one-cycle request to begin an exhaustive sweep.
REQ-006 SHALL have port lhs  input  1  the DUT left-hand-side expression result.
REQ-007 SHALL have port rhs  input  1  the DUT right-hand-side expression result.
REQ-008 SHALL have port vec_out  output  N_IN  the vector applied to the DUT; MSB drives X, LSB drives Z.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  high from sweep completion until the next start or reset.
REQ-011 SHALL have port pass  output  1  equal to done AND (mismatch_cnt == 0).
REQ-012 SHALL have port mismatch_cnt  output  N_IN+1  the number of vectors where lhs != rhs.
REQ-013 SHALL have port first_fail_vec  output  N_IN  the lowest vector that mismatched.
REQ-014 SHALL have port first_fail_valid  output  1  high once first_fail_vec holds a captured vector.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, DONE; reset state IDLE.
REQ-016 In IDLE or DONE, start=1 at edge k SHALL load vec_out=0, clear mismatch_cnt, first_fail_vec and first_fail_valid, load the settle counter with SETTLE, and enter HOLD with busy=1 and done=0.
REQ-017 In HOLD, the settle counter SHALL decrement each cycle while nonzero; lhs/rhs SHALL be compared only at the edge where the counter is 0, so each vector is held exactly SETTLE+1 cycles.
REQ-018 At a compare edge with lhs != rhs, mismatch_cnt SHALL increment by 1; if first_fail_valid=0, first_fail_vec SHALL load vec_out and first_fail_valid SHALL set.
REQ-019 At a compare edge with vec_out < 2^N_IN-1, vec_out SHALL increment by 1 and the settle counter SHALL reload SETTLE.
REQ-020 At a compare edge with vec_out = 2^N_IN-1, the FSM SHALL enter DONE, with busy=0 and done=1; vec_out SHALL hold all-ones and SHALL NOT wrap.
REQ-021 done SHALL first be high in the cycle after edge k+2^N_IN*(SETTLE+1); for defaults this is edge k+24.
REQ-022 mismatch_cnt SHALL be N_IN+1 bits wide and SHALL be able to reach 2^N_IN without overflow.
REQ-023 start SHALL be ignored in HOLD.
REQ-024 start in DONE SHALL restart the sweep per REQ-016; done SHALL drop at that same edge.
REQ-025 pass SHALL be combinational from done and mismatch_cnt and SHALL be 0 whenever done=0.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, vec_out=0, busy=0, done=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, and settle counter=0, regardless of clk.
REQ-027 Reset asserted mid-sweep SHALL abandon the sweep; no partial result SHALL be retained.
REQ-028 After reset deassertion, the block SHALL stay in IDLE until start is seen.

Structure
REQ-029 The FSM state encoding and a default-settle constant SHALL live in a shared package, equiv_pkg.
REQ-030 The settle countdown SHALL be a sub-module named settle_timer with load, value and zero-flag ports; all other logic SHALL stay in equiv_checker.

Verification
REQ-031 Drive rhs=lhs for all vectors, pulse start -> done at edge k+24, pass=1, mismatch_cnt=0, first_fail_valid=0.
REQ-032 Drive rhs=~lhs -> mismatch_cnt=8, first_fail_vec=3'b000, pass=0.
REQ-033 Force a mismatch only at vector 3'b101 -> mismatch_cnt=1, first_fail_vec=3'b101, first_fail_valid=1.
REQ-034 Pulse start again at edge k+10 -> ignored, and done still occurs at edge k+24.
REQ-035 Assert rst_n=0 at edge k+13 -> all outputs go to reset values at once; a new start then gives a full 24-cycle sweep.
REQ-036 Pulse start in DONE after a failing sweep -> done drops, mismatch_cnt and first_fail_valid clear, and a second sweep with matching DUT gives pass=1.
